// File: rtl/vram_arb_pkg.sv
// Shared types for the video-RAM arbiter: source tags, CPU read states, posted-write entries.
package vram_arb_pkg;

   localparam int unsigned VRAM_ADDR_W = 15;
   localparam int unsigned VRAM_DATA_W = 8;

   // Owner of a RAM read travelling down the tag pipeline
   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_VID  = 2'd1,
      SRC_CPU  = 2'd2
   } src_t;

   // CPU read sequencing
   typedef enum logic [1:0] {
      C_IDLE  = 2'd0,
      C_DRAIN = 2'd1,
      C_ISSUE = 2'd2,
      C_WAIT  = 2'd3
   } cpu_st_t;

   // One posted CPU write
   typedef struct packed {
      logic [VRAM_ADDR_W-1:0] addr;
      logic [VRAM_DATA_W-1:0] data;
   } wr_entry_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bus bundle between video fetch / CPU decoder / screen BRAM and the arbiter.
interface vram_arbiter_if #(
   parameter int unsigned ADDR_W     = 15,
   parameter int unsigned FIFO_DEPTH = 4
);
   localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic [7:0]        vid_data;
   logic              vid_valid;

   logic              cpu_wr_req;
   logic              cpu_rd_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic [7:0]        cpu_din;
   logic              cpu_wr_ack;
   logic              cpu_busy;
   logic [7:0]        cpu_rd_data;
   logic              cpu_rd_valid;
   logic [LVL_W-1:0]  fifo_level;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [7:0]        ram_din;
   logic [7:0]        ram_dout;

   // Requesters and the BRAM side
   modport master (
      output vid_req, vid_addr, cpu_wr_req, cpu_rd_req, cpu_addr, cpu_din, ram_dout,
      input  vid_data, vid_valid, cpu_wr_ack, cpu_busy, cpu_rd_data, cpu_rd_valid,
             fifo_level, ram_addr, ram_we, ram_din
   );

   // Arbiter side
   modport slave (
      input  vid_req, vid_addr, cpu_wr_req, cpu_rd_req, cpu_addr, cpu_din, ram_dout,
      output vid_data, vid_valid, cpu_wr_ack, cpu_busy, cpu_rd_data, cpu_rd_valid,
             fifo_level, ram_addr, ram_we, ram_din
   );

endinterface

// File: rtl/vram_wr_fifo.sv
// Synchronous posted-write FIFO; pointers carry one extra wrap bit for full/empty.
module vram_wr_fifo
   import vram_arb_pkg::*;
#(
   parameter int unsigned DEPTH   = 4,
   parameter type         entry_t = wr_entry_t
) (
   input  logic                       clk_sys,
   input  logic                       nRESET,
   input  logic                       push,
   input  entry_t                     din,
   input  logic                       pop,
   output entry_t                     dout_c,
   output logic                       full_c,
   output logic                       empty_c,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned PW    = PTR_W + 1;

   logic [PTR_W:0] wr_ptr;
   logic [PTR_W:0] rd_ptr;
   entry_t         mem [DEPTH];
   logic           do_push;
   logic           do_pop;

   assign empty_c = (wr_ptr == rd_ptr);
   assign full_c  = (wr_ptr == {~rd_ptr[PTR_W], rd_ptr[PTR_W-1:0]});
   assign dout_c  = mem[rd_ptr[PTR_W-1:0]];
   // A push into a full FIFO is legal only when the head leaves in the same cycle
   assign do_push = push & (~full_c | pop);
   assign do_pop  = pop & ~empty_c;

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   level <= level + PW'(1);
            2'b01:   level <= level - PW'(1);
            default: level <= level;
         endcase
      end
   end

   // Entry storage; stale slots are masked by the pointers, so no reset
   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
   end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video has absolute priority, CPU writes are posted,
// CPU reads wait for the posted writes to drain so they observe them.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = VRAM_ADDR_W,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned RAM_LAT    = 1
) (
   input  logic          clk_sys,
   input  logic          nRESET,
   vram_arbiter_if.slave bus
);
   localparam int unsigned TAG_LAST = RAM_LAT;

   cpu_st_t           state;
   cpu_st_t           state_nx;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W-1:0] rd_addr_nx;
   logic              busy_q;

   logic              push_c;
   logic              pop_c;
   logic              full_c;
   logic              empty_c;
   wr_entry_t         wr_in_c;
   wr_entry_t         head_c;

   logic              op_load_c;
   logic              op_we_c;
   src_t              op_src_c;
   logic [ADDR_W-1:0] op_addr_c;
   logic [7:0]        op_din_c;

   src_t              tag_q [RAM_LAT+1];
   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_we_q;
   logic [7:0]        ram_din_q;
   logic [7:0]        vid_data_q;
   logic              vid_valid_q;
   logic [7:0]        rd_data_q;
   logic              rd_valid_q;

   assign wr_in_c = '{addr: VRAM_ADDR_W'(bus.cpu_addr), data: bus.cpu_din};

   vram_wr_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (wr_entry_t)
   ) u_wr_fifo (
      .clk_sys (clk_sys),
      .nRESET  (nRESET),
      .push    (push_c),
      .din     (wr_in_c),
      .pop     (pop_c),
      .dout_c  (head_c),
      .full_c  (full_c),
      .empty_c (empty_c),
      .level   (bus.fifo_level)
   );

   assign bus.cpu_wr_ack   = push_c;
   assign bus.cpu_busy     = busy_q;
   assign bus.ram_addr     = ram_addr_q;
   assign bus.ram_we       = ram_we_q;
   assign bus.ram_din      = ram_din_q;
   assign bus.vid_data     = vid_data_q;
   assign bus.vid_valid    = vid_valid_q;
   assign bus.cpu_rd_data  = rd_data_q;
   assign bus.cpu_rd_valid = rd_valid_q;

   // CPU read state and latched read address
   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         state     <= C_IDLE;
         rd_addr_q <= '0;
         busy_q    <= 1'b0;
      end else begin
         state     <= state_nx;
         rd_addr_q <= rd_addr_nx;
         busy_q    <= (state_nx != C_IDLE);
      end
   end

   // Priority mux (video > drain > CPU read), write acceptance and read sequencing
   always_comb begin
      state_nx   = state;
      rd_addr_nx = rd_addr_q;
      pop_c      = 1'b0;
      op_load_c  = 1'b0;
      op_we_c    = 1'b0;
      op_src_c   = SRC_NONE;
      op_addr_c  = ram_addr_q;
      op_din_c   = ram_din_q;

      if (bus.vid_req) begin
         op_load_c = 1'b1;
         op_src_c  = SRC_VID;
         op_addr_c = bus.vid_addr;
      end else if (!empty_c) begin
         pop_c     = 1'b1;
         op_load_c = 1'b1;
         op_we_c   = 1'b1;
         op_addr_c = ADDR_W'(head_c.addr);
         op_din_c  = head_c.data;
      end else if (state == C_ISSUE) begin
         op_load_c = 1'b1;
         op_src_c  = SRC_CPU;
         op_addr_c = rd_addr_q;
      end

      push_c = bus.cpu_wr_req & ~busy_q & (~full_c | pop_c);

      case (state)
         C_IDLE: begin
            if (bus.cpu_rd_req) begin
               state_nx   = C_DRAIN;
               rd_addr_nx = bus.cpu_addr;
            end
         end
         C_DRAIN: if (empty_c)                   state_nx = C_ISSUE;
         C_ISSUE: if (!bus.vid_req)              state_nx = C_WAIT;
         C_WAIT:  if (tag_q[TAG_LAST] == SRC_CPU) state_nx = C_IDLE;
         default:                                state_nx = C_IDLE;
      endcase
   end

   // Registered RAM port, tag pipeline and returned-data routing
   always_ff @(posedge clk_sys or negedge nRESET) begin
      if (!nRESET) begin
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_din_q   <= '0;
         vid_data_q  <= '0;
         vid_valid_q <= 1'b0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         for (int unsigned i = 0; i <= RAM_LAT; i++) tag_q[i] <= SRC_NONE;
      end else begin
         ram_we_q <= op_we_c;
         if (op_load_c) ram_addr_q <= op_addr_c;
         if (op_we_c)   ram_din_q  <= op_din_c;

         tag_q[0] <= op_src_c;
         for (int unsigned i = 1; i <= RAM_LAT; i++) tag_q[i] <= tag_q[i-1];

         vid_valid_q <= (tag_q[TAG_LAST] == SRC_VID);
         rd_valid_q  <= (tag_q[TAG_LAST] == SRC_CPU);
         if (tag_q[TAG_LAST] == SRC_VID) vid_data_q <= bus.ram_dout;
         if (tag_q[TAG_LAST] == SRC_CPU) rd_data_q  <= bus.ram_dout;
      end
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Randomised + directed bench for vram_arbiter against a transaction-level model.
module tb_vram_arbiter;
   localparam int unsigned AW    = 15;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned MSIZE = 32768;

   typedef struct { logic [AW-1:0] addr; logic [7:0] data; } wr_t;
   typedef struct { int unsigned due; logic [7:0] data; } vexp_t;

   logic clk_sys = 1'b0;
   logic nRESET;
   always #5 clk_sys = ~clk_sys;

   vram_arbiter_if #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH)) bus ();

   vram_arbiter #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .RAM_LAT(1)) dut (
      .clk_sys (clk_sys),
      .nRESET  (nRESET),
      .bus     (bus)
   );

   // Screen BRAM, one cycle read latency, preloaded with addr[7:0]
   logic [7:0] tb_ram [MSIZE];
   logic       ram_init = 1'b0;
   always @(posedge clk_sys) begin
      if (!ram_init) begin
         for (int i = 0; i < int'(MSIZE); i++) tb_ram[i] <= 8'(i);
         ram_init <= 1'b1;
      end else if (bus.ram_we) begin
         tb_ram[bus.ram_addr] <= bus.ram_din;
      end
      bus.ram_dout <= tb_ram[bus.ram_addr];
   end

   // Model state: physical RAM image, CPU-visible image, posted writes, pending video returns
   logic [7:0]    phys [MSIZE];
   logic [7:0]    arch [MSIZE];
   wr_t           wq[$];
   vexp_t         vq[$];
   logic [7:0]    vid_seen[$];
   bit            m_busy;
   logic [AW-1:0] rd_addr;
   logic [7:0]    rd_exp;
   int unsigned   busy_cnt;
   logic [AW-1:0] last_addr;
   logic [7:0]    last_din;
   int unsigned   cyc;
   bit            last_ack, dut_ack, saw_rd;
   logic [7:0]    rd_seen;
   int unsigned   vid_pulses, rd_pulses, we_seen;
   int unsigned   n_chk, n_pass;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic idle_inputs();
      bus.vid_req = 1'b0; bus.vid_addr = '0;
      bus.cpu_wr_req = 1'b0; bus.cpu_rd_req = 1'b0; bus.cpu_addr = '0; bus.cpu_din = '0;
   endtask

   // One clock: predict from the current inputs, advance, compare every output
   task automatic tick();
      logic          exp_ack, exp_we, idle_op, rd_can_issue;
      logic [AW-1:0] exp_addr;
      logic [7:0]    exp_din;
      wr_t           h;
      #1;
      exp_ack = bus.cpu_wr_req && !m_busy &&
                (wq.size() < DEPTH || (!bus.vid_req && wq.size() != 0));
      dut_ack = bus.cpu_wr_ack;
      chk("cpu_wr_ack", 32'(bus.cpu_wr_ack), 32'(exp_ack));
      last_ack = exp_ack;
      exp_we = 1'b0; idle_op = 1'b0; exp_addr = last_addr; exp_din = last_din;
      rd_can_issue = m_busy && wq.size() == 0;
      if (bus.vid_req) begin
         exp_addr = bus.vid_addr;
         vq.push_back('{due: cyc + 3, data: phys[bus.vid_addr]});
      end else if (wq.size() != 0) begin
         h = wq.pop_front();
         phys[h.addr] = h.data;
         exp_we = 1'b1; exp_addr = h.addr; exp_din = h.data;
      end else begin
         idle_op = 1'b1;
      end
      if (exp_ack) begin
         wq.push_back('{addr: bus.cpu_addr, data: bus.cpu_din});
         arch[bus.cpu_addr] = bus.cpu_din;
      end
      if (bus.cpu_rd_req && !m_busy) begin
         m_busy = 1'b1; rd_addr = bus.cpu_addr; rd_exp = arch[bus.cpu_addr]; busy_cnt = 0;
      end
      @(posedge clk_sys);
      cyc++;
      @(negedge clk_sys);
      chk("ram_we", 32'(bus.ram_we), 32'(exp_we));
      if (bus.ram_we) we_seen++;
      chk("ram_din", 32'(bus.ram_din), 32'(exp_din));
      if (idle_op && rd_can_issue && bus.ram_addr == rd_addr) exp_addr = rd_addr;
      chk("ram_addr", 32'(bus.ram_addr), 32'(exp_addr));
      last_addr = exp_addr; last_din = exp_din;
      chk("fifo_level", 32'(bus.fifo_level), 32'(wq.size()));
      if (vq.size() != 0 && vq[0].due == cyc) begin
         chk("vid_valid", 32'(bus.vid_valid), 32'd1);
         chk("vid_data", 32'(bus.vid_data), 32'(vq[0].data));
         vid_seen.push_back(bus.vid_data);
         void'(vq.pop_front());
      end else begin
         chk("vid_valid", 32'(bus.vid_valid), 32'd0);
      end
      if (bus.vid_valid) vid_pulses++;
      if (bus.cpu_rd_valid) begin
         rd_pulses++;
         chk("rd_valid_while_pending", 32'(m_busy), 32'd1);
         if (m_busy) begin
            chk("cpu_rd_data", 32'(bus.cpu_rd_data), 32'(rd_exp));
            rd_seen = bus.cpu_rd_data; saw_rd = 1'b1; m_busy = 1'b0;
         end
      end
      chk("cpu_busy", 32'(bus.cpu_busy), 32'(m_busy));
      if (m_busy) begin
         busy_cnt++;
         if (busy_cnt > 400) begin
            n_chk++;
            $display("FAIL read_timeout: got no cpu_rd_valid after %0d cycles, expected one", busy_cnt);
            m_busy = 1'b0;
         end
      end
   endtask

   // Asynchronous reset in mid-cycle; posted writes are lost, so the CPU view reverts
   task automatic do_reset();
      #2;
      nRESET = 1'b0;
      idle_inputs();
      #1;
      chk("rst_vid_valid", 32'(bus.vid_valid), 32'd0);
      chk("rst_rd_valid", 32'(bus.cpu_rd_valid), 32'd0);
      chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
      chk("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
      chk("rst_cpu_busy", 32'(bus.cpu_busy), 32'd0);
      chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
      foreach (wq[i]) arch[wq[i].addr] = phys[wq[i].addr];
      wq.delete(); vq.delete();
      m_busy = 1'b0; last_addr = '0; last_din = '0;
      repeat (2) @(negedge clk_sys);
      nRESET = 1'b1;
   endtask

   initial begin
      int widx;
      bit wr_pend;
      logic [AW-1:0] w_addr;
      logic [7:0] w_data;
      n_chk = 0; n_pass = 0; cyc = 0; m_busy = 1'b0; busy_cnt = 0;
      last_addr = '0; last_din = '0; last_ack = 1'b0; dut_ack = 1'b0; saw_rd = 1'b0;
      rd_addr = '0; rd_exp = '0; rd_seen = '0; vid_pulses = 0; rd_pulses = 0; we_seen = 0;
      for (int i = 0; i < int'(MSIZE); i++) begin phys[i] = 8'(i); arch[i] = 8'(i); end
      nRESET = 1'b0;
      idle_inputs();
      repeat (3) @(negedge clk_sys);

      // Reset state
      chk("reset_vid_valid", 32'(bus.vid_valid), 32'd0);
      chk("reset_vid_data", 32'(bus.vid_data), 32'd0);
      chk("reset_rd_valid", 32'(bus.cpu_rd_valid), 32'd0);
      chk("reset_rd_data", 32'(bus.cpu_rd_data), 32'd0);
      chk("reset_busy", 32'(bus.cpu_busy), 32'd0);
      chk("reset_level", 32'(bus.fifo_level), 32'd0);
      chk("reset_ram_we", 32'(bus.ram_we), 32'd0);
      chk("reset_ram_din", 32'(bus.ram_din), 32'd0);
      nRESET = 1'b1;

      // Idle after reset: RAM never written
      repeat (20) tick();
      chk("idle_ram_we_count", 32'(we_seen), 32'd0);

      // Back-to-back video fetches
      vid_seen.delete();
      for (int i = 0; i < 8; i++) begin
         bus.vid_req = 1'b1; bus.vid_addr = AW'(i);
         tick();
      end
      bus.vid_req = 1'b0;
      repeat (3) tick();
      chk("vid_burst_count", 32'(vid_seen.size()), 32'd8);
      for (int i = 0; i < 8 && i < vid_seen.size(); i++) chk("vid_burst_data", 32'(vid_seen[i]), 32'(i));

      // FIFO fills under continuous video, then drains in order
      widx = 0;
      bus.vid_req = 1'b1; bus.vid_addr = AW'('h40);
      for (int c = 0; c < 8; c++) begin
         bus.cpu_wr_req = (widx < 6);
         bus.cpu_addr = AW'('h1800 + widx); bus.cpu_din = 8'('hA0 + widx);
         tick();
         if (last_ack) widx++;
      end
      chk("full_level", 32'(bus.fifo_level), 32'd4);
      chk("full_acked", 32'(widx), 32'd4);
      bus.vid_req = 1'b0;
      for (int c = 0; c < 20 && !(widx == 6 && bus.fifo_level == 0); c++) begin
         bus.cpu_wr_req = (widx < 6);
         bus.cpu_addr = AW'('h1800 + widx); bus.cpu_din = 8'('hA0 + widx);
         tick();
         if (last_ack) widx++;
      end
      bus.cpu_wr_req = 1'b0;
      repeat (2) tick();
      chk("drain_acked", 32'(widx), 32'd6);
      chk("drain_level", 32'(bus.fifo_level), 32'd0);
      for (int i = 0; i < 6; i++) chk("drain_ram", 32'(tb_ram[AW'('h1800 + i)]), 32'('hA0 + i));

      // Read-after-write with alternating video
      bus.cpu_wr_req = 1'b1; bus.cpu_addr = AW'('h1234); bus.cpu_din = 8'h55;
      for (int c = 0; c < 10; c++) begin tick(); if (last_ack) break; end
      bus.cpu_wr_req = 1'b0;
      saw_rd = 1'b0;
      bus.cpu_rd_req = 1'b1; bus.vid_req = 1'b1; bus.vid_addr = AW'('h300);
      tick();
      bus.cpu_rd_req = 1'b0;
      for (int c = 1; c < 60 && !saw_rd; c++) begin
         bus.vid_req = (c % 2 == 0); bus.vid_addr = AW'('h300 + c);
         tick();
      end
      bus.vid_req = 1'b0;
      chk("raw_read_seen", 32'(saw_rd), 32'd1);
      chk("raw_read_data", 32'(rd_seen), 32'h55);
      repeat (3) tick();

      // Writes blocked while a read is outstanding
      saw_rd = 1'b0;
      bus.vid_req = 1'b1; bus.vid_addr = AW'('h10);
      bus.cpu_rd_req = 1'b1; bus.cpu_addr = AW'('h1800);
      tick();
      bus.cpu_rd_req = 1'b0;
      bus.cpu_wr_req = 1'b1; bus.cpu_addr = AW'('h1900); bus.cpu_din = 8'h77;
      for (int c = 0; c < 60 && !saw_rd; c++) begin
         bus.vid_req = (c < 6);
         tick();
      end
      bus.vid_req = 1'b0;
      chk("busy_read_data", 32'(rd_seen), 32'hA0);
      tick();
      chk("ack_after_read", 32'(dut_ack), 32'd1);
      bus.cpu_wr_req = 1'b0;
      repeat (3) tick();

      // Reset with three posted writes and a read waiting on them
      widx = 0;
      bus.vid_req = 1'b1; bus.vid_addr = AW'('h22);
      for (int c = 0; c < 10 && widx < 3; c++) begin
         bus.cpu_wr_req = 1'b1; bus.cpu_addr = AW'('h0700 + widx); bus.cpu_din = 8'('hC0 + widx);
         tick();
         if (last_ack) widx++;
      end
      bus.cpu_wr_req = 1'b0;
      chk("pre_reset_level", 32'(bus.fifo_level), 32'd3);
      bus.cpu_rd_req = 1'b1; bus.cpu_addr = AW'('h0700);
      tick();
      bus.cpu_rd_req = 1'b0;
      tick();
      vid_pulses = 0; rd_pulses = 0;
      do_reset();
      repeat (12) tick();
      chk("post_reset_vid_pulses", 32'(vid_pulses), 32'd0);
      chk("post_reset_rd_pulses", 32'(rd_pulses), 32'd0);
      chk("post_reset_level", 32'(bus.fifo_level), 32'd0);
      for (int i = 0; i < 3; i++) chk("lost_write_ram", 32'(tb_ram[AW'('h0700 + i)]), 32'(i));

      // Reset while a read is in flight in the RAM
      bus.cpu_rd_req = 1'b1; bus.cpu_addr = AW'('h1801);
      tick();
      bus.cpu_rd_req = 1'b0;
      repeat (2) tick();
      rd_pulses = 0;
      do_reset();
      repeat (10) tick();
      chk("inflight_read_dropped", 32'(rd_pulses), 32'd0);

      // Random traffic
      wr_pend = 1'b0; w_addr = '0; w_data = '0;
      for (int c = 0; c < 1500; c++) begin
         bus.vid_req = ($urandom_range(99) < 35);
         bus.vid_addr = ($urandom_range(1) == 0) ? AW'($urandom) : AW'('h100 + $urandom_range(15));
         if (!wr_pend && $urandom_range(99) < 30) begin
            wr_pend = 1'b1;
            w_addr = AW'('h100 + $urandom_range(15));
            w_data = 8'($urandom);
         end
         bus.cpu_wr_req = wr_pend;
         bus.cpu_din = w_data;
         bus.cpu_addr = wr_pend ? w_addr : AW'('h100 + $urandom_range(15));
         bus.cpu_rd_req = ($urandom_range(99) < 12);
         tick();
         if (last_ack) wr_pend = 1'b0;
      end
      idle_inputs();
      repeat (40) tick();
      for (int i = 'h100; i < 'h110; i++) chk("final_ram", 32'(tb_ram[i]), 32'(phys[i]));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
